// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div over a fixed busy
// window, and serves mthi/mtlo/mfhi/mflo beside the ALU.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk_In,
    input  logic        Reset_In,
    input  logic        Valid_In,
    input  logic [5:0]  Op_In,
    input  logic [5:0]  Func_In,
    input  logic [31:0] SrcA_In,
    input  logic [31:0] SrcB_In,
    output logic        Start_Out,
    output logic        Busy_Out,
    output logic [31:0] Md_Out,
    output logic [31:0] Hi_Out,
    output logic [31:0] Lo_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    logic             is_special;
    logic             is_mult, is_multu, is_div, is_divu;
    logic             is_mthi, is_mtlo, is_mfhi, is_mflo;
    logic             is_md_start;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q, lo_q, sh_q, sl_q;
    logic             commit_q;
    logic [63:0]      result;
    logic             result_ok;
    logic [31:0]      divisor;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      quot_s, rem_s, quot_u, rem_u;

    assign is_special  = Valid_In && (Op_In == 6'b000000);
    assign is_mult     = is_special && (Func_In == FN_MULT);
    assign is_multu    = is_special && (Func_In == FN_MULTU);
    assign is_div      = is_special && (Func_In == FN_DIV);
    assign is_divu     = is_special && (Func_In == FN_DIVU);
    assign is_mthi     = is_special && (Func_In == FN_MTHI);
    assign is_mtlo     = is_special && (Func_In == FN_MTLO);
    assign is_mfhi     = is_special && (Func_In == FN_MFHI);
    assign is_mflo     = is_special && (Func_In == FN_MFLO);
    assign is_md_start = is_mult || is_multu || is_div || is_divu;

    // Issue handshake: an MD op is accepted on the edge where Start_Out=1
    // (decoded and not busy); anything decoded while busy is dropped.
    assign Start_Out = is_md_start && !Busy_Out;

    // Divisor forced non-zero so the datapath never produces X; the result is discarded anyway.
    assign divisor = (SrcB_In == 32'd0) ? 32'd1 : SrcB_In;

    always_comb begin
        prod_s = $signed({{32{SrcA_In[31]}}, SrcA_In}) * $signed({{32{SrcB_In[31]}}, SrcB_In});
        prod_u = {32'd0, SrcA_In} * {32'd0, SrcB_In};
        quot_u = SrcA_In / divisor;
        rem_u  = SrcA_In % divisor;
        if (SrcA_In == 32'h8000_0000 && SrcB_In == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(SrcA_In) / $signed(divisor);
            rem_s  = $signed(SrcA_In) % $signed(divisor);
        end
    end

    always_comb begin
        result    = prod_u;
        result_ok = 1'b1;
        if (is_mult) begin
            result = prod_s;
        end else if (is_div) begin
            result    = {rem_s, quot_s};
            result_ok = (SrcB_In != 32'd0);
        end else if (is_divu) begin
            result    = {rem_u, quot_u};
            result_ok = (SrcB_In != 32'd0);
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            sh_q     <= 32'd0;
            sl_q     <= 32'd0;
            commit_q <= 1'b0;
            cnt      <= '0;
            Busy_Out <= 1'b0;
        end else if (Busy_Out) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                Busy_Out <= 1'b0;
                if (commit_q) begin
                    hi_q <= sh_q;
                    lo_q <= sl_q;
                end
            end
        end else if (Start_Out) begin
            sh_q     <= result[63:32];
            sl_q     <= result[31:0];
            commit_q <= result_ok;
            cnt      <= (is_mult || is_multu) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            Busy_Out <= 1'b1;
        end else begin
            if (is_mthi) hi_q <= SrcA_In;
            if (is_mtlo) lo_q <= SrcA_In;
        end
    end

    assign Md_Out = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);
    assign Hi_Out = hi_q;
    assign Lo_Out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected {HI,LO} pairs are queued at issue
// and compared when Busy_Out falls.
module tb_mult_div_unit;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] src_a, src_b;
    logic        start_out, busy_out;
    logic [31:0] md_out, hi_out, lo_out;

    logic [63:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .Valid_In (valid),
        .Op_In    (op),
        .Func_In  (func),
        .SrcA_In  (src_a),
        .SrcB_In  (src_b),
        .Start_Out(start_out),
        .Busy_Out (busy_out),
        .Md_Out   (md_out),
        .Hi_Out   (hi_out),
        .Lo_Out   (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Drive an op at the current (non-edge) time, step past the next edge, then idle.
    task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; op = 6'd0; func = fn; src_a = a; src_b = b;
        @(posedge clk); #1;
        valid = 1'b0; func = 6'd0; src_a = 32'd0; src_b = 32'd0;
    endtask

    task automatic start_op(input string tag, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
        valid = 1'b1; op = 6'd0; func = fn; src_a = a; src_b = b;
        #1 check({tag, "_start"}, 64'(start_out), 64'd1);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        valid = 1'b0; func = 6'd0; src_a = 32'd0; src_b = 32'd0;
    endtask

    // Counts busy cycles from now until Busy_Out drops, then scoreboards {HI,LO}.
    task automatic wait_done(input string tag, input int n_busy);
        int cnt = 0;
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!busy_out) done = 1'b1;
            else cnt++;
        end
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(n_busy));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            check({tag, "_hilo"}, {hi_out, lo_out}, exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = 6'd0; func = 6'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy_out), 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        check("reset_md", 64'(md_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed vs unsigned multiply, issued back to back
        start_op("mult_neg", FN_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_done("mult_neg", 5);
        start_op("multu", FN_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        wait_done("multu", 5);

        // Divides
        start_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div_neg", 10);
        start_op("divu", FN_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        wait_done("divu", 10);

        // Divide by zero keeps HI/LO
        drive(FN_MTHI, 32'd0, 32'd0);
        drive(FN_MTLO, 32'h1234, 32'd0);
        check("mtlo", {hi_out, lo_out}, 64'h0000_0000_0000_1234);
        start_op("divu_zero", FN_DIVU, 32'd5, 32'd0, 64'h0000_0000_0000_1234);
        wait_done("divu_zero", 10);
        start_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done("div_ovf", 10);

        // mthi and a second mult while busy are both ignored
        start_op("mult_3x4", FN_MULT, 32'd3, 32'd4, 64'd12);
        @(posedge clk); #1;
        valid = 1'b1; func = FN_MTHI; src_a = 32'hAAAA;
        #1 check("busy_mthi_start", 64'(start_out), 64'd0);
        @(posedge clk); #1;
        valid = 1'b1; func = FN_MULT; src_a = 32'd7; src_b = 32'd9;
        #1 check("busy_mult_start", 64'(start_out), 64'd0);
        @(posedge clk); #1;
        valid = 1'b0; func = 6'd0; src_a = 32'd0; src_b = 32'd0;
        check("busy_hi_untouched", 64'(hi_out), 64'd0);
        wait_done("mult_3x4", 2);

        // Reset mid-operation discards the op
        drive(FN_MULT, 32'd3, 32'd4);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1 check("midreset_busy", 64'(busy_out), 64'd0);
        check("midreset_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midreset_no_write", {hi_out, lo_out}, 64'd0);
        check("midreset_idle", 64'(busy_out), 64'd0);

        // mflo in the first idle cycle sees the new LO
        start_op("mult_2x3", FN_MULT, 32'd2, 32'd3, 64'd6);
        wait_done("mult_2x3", 5);
        valid = 1'b1; func = FN_MFLO;
        #1 check("mflo", 64'(md_out), 64'd6);
        func = FN_MFHI;
        #1 check("mfhi", 64'(md_out), 64'd0);
        valid = 1'b0; func = FN_MFLO;
        #1 check("bubble_md", 64'(md_out), 64'd0);
        func = FN_MULT; src_a = 32'd5; src_b = 32'd5;
        #1 check("bubble_start", 64'(start_out), 64'd0);
        @(posedge clk); #1;
        check("bubble_busy", 64'(busy_out), 64'd0);
        check("bubble_hilo", {hi_out, lo_out}, 64'd6);
        func = 6'd0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
